// File: rtl/gamma_pipe_razor_mc.sv
// Multi-lane gamma combiner: scaled ba1 + ba3 (stage 1), then + ba2 with saturation (stage 2); 2-edge latency.
// Razor error or low Enable freezes both stages; error is forwarded one cycle later, stalls and clips are counted.
module gamma_pipe_razor_mc #(
    parameter int N  = 5,
    parameter int M  = 6,
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  error_previous_i,
    input  logic                  in_valid_i,
    input  logic [1:0]            scale_mode_i,
    input  logic [CH*M-1:0]       ba1_i,
    input  logic [CH*N-1:0]       ba2_i,
    input  logic [CH*N-1:0]       ba3_i,
    output logic                  out_valid_o,
    output logic [CH*(M+1)-1:0]   ba1ba3_o,
    output logic [CH*(M+1)-1:0]   ba1ba2ba3_o,
    output logic                  error_out_o,
    output logic [CW-1:0]         sat_count_o,
    output logic [CW-1:0]         stall_count_o
);

    localparam logic [CW:0] CNT_MAX = {1'b0, {CW{1'b1}}};

    logic                adv;
    logic signed [M+2:0] ext      [CH];
    logic signed [M+2:0] prod     [CH];
    logic        [M:0]   s1_sum_d [CH];
    logic        [M+1:0] wide     [CH];
    logic        [M:0]   sat_d    [CH];
    logic [CH-1:0]       clip;
    logic [CW:0]         nclip;
    logic [CW:0]         sat_sum;
    logic [CW-1:0]       sat_count_d;

    logic                s1_valid_q;
    logic        [M:0]   s1_sum_q [CH];
    logic                out_valid_q;
    logic        [M:0]   o13_q    [CH];
    logic        [M:0]   o123_q   [CH];
    logic                err_q;
    logic [CW-1:0]       sat_count_q;
    logic [CW-1:0]       stall_count_q;

    assign adv = enable_i && !error_previous_i;

    always_comb begin
        nclip = '0;
        for (int i = 0; i < CH; i++) begin
            ext[i] = {{3{ba1_i[i*M+M-1]}}, ba1_i[i*M +: M]};
            // The M+3-bit product holds 7*ba1 exactly, so the floor shift is exact.
            case (scale_mode_i)
                2'd0:    prod[i] = ext[i] >>> 1;
                2'd1:    prod[i] = (ext[i] + (ext[i] <<< 1)) >>> 2;
                2'd2:    prod[i] = ext[i];
                default: prod[i] = ((ext[i] <<< 3) - ext[i]) >>> 3;
            endcase
            s1_sum_d[i] = {prod[i][M-1], prod[i][M-1:0]}
                        + {{(M+1-N){ba3_i[i*N+N-1]}}, ba3_i[i*N +: N]};

            wide[i] = {s1_sum_q[i][M], s1_sum_q[i]}
                    + {{(M+2-N){ba2_i[i*N+N-1]}}, ba2_i[i*N +: N]};
            clip[i] = wide[i][M+1] ^ wide[i][M];
            if (clip[i])
                sat_d[i] = wide[i][M+1] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
            else
                sat_d[i] = wide[i][M:0];
            nclip = nclip + {{CW{1'b0}}, clip[i]};
        end
        sat_sum     = {1'b0, sat_count_q} + nclip;
        sat_count_d = (sat_sum > CNT_MAX) ? CNT_MAX[CW-1:0] : sat_sum[CW-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            sat_count_q   <= '0;
            stall_count_q <= '0;
            for (int i = 0; i < CH; i++) begin
                s1_sum_q[i] <= '0;
                o13_q[i]    <= '0;
                o123_q[i]   <= '0;
            end
        end else if (clear_i) begin
            s1_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            sat_count_q   <= '0;
            stall_count_q <= '0;
            for (int i = 0; i < CH; i++) begin
                s1_sum_q[i] <= '0;
                o13_q[i]    <= '0;
                o123_q[i]   <= '0;
            end
        end else begin
            err_q <= error_previous_i;
            if (error_previous_i && (stall_count_q != CNT_MAX[CW-1:0]))
                stall_count_q <= stall_count_q + 1'b1;
            if (adv) begin
                s1_valid_q  <= in_valid_i;
                out_valid_q <= s1_valid_q;
                if (s1_valid_q)
                    sat_count_q <= sat_count_d;
                for (int i = 0; i < CH; i++) begin
                    s1_sum_q[i] <= s1_sum_d[i];
                    o13_q[i]    <= s1_sum_q[i];
                    o123_q[i]   <= sat_d[i];
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_pack
        assign ba1ba3_o[g*(M+1) +: M+1]    = o13_q[g];
        assign ba1ba2ba3_o[g*(M+1) +: M+1] = o123_q[g];
    end

    assign out_valid_o   = out_valid_q;
    assign error_out_o   = err_q;
    assign sat_count_o   = sat_count_q;
    assign stall_count_o = stall_count_q;

endmodule

// File: doc/gamma_pipe_razor_mc.md
# gamma_pipe_razor_mc

Multi-lane, two-stage successor to the single-lane gamma combiner in the FPTD datapath. For each of CH lanes it scales the a-priori term ba1 by a run-time-selectable factor, adds ba3, then adds ba2 with saturation. Razor error stalls arrive from the upstream stage and are propagated one cycle later to the downstream stage. Saturation events and stall cycles are counted for the error-rate monitor.

## Interface
- N, 5: ba2/ba3 lane width (signed); N <= M required
- M, 6: ba1 lane width (signed); outputs are M+1 bits per lane
- CH, 4: number of parallel lanes
- CW, 8: width of the saturation and stall counters

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- Clear  in  1  synchronous active-high flush; clears all state
- Enable  in  1  pipeline advance enable
- Error_previous  in  1  razor error from upstream; freezes the pipeline
- in_valid  in  1  lane inputs valid this cycle
- Scale_mode  in  2  ba1 scale select, sampled with the data
- ba1  in  CH*M  lane i occupies [i*M +: M]
- ba2, ba3  in  CH*N each  lane i occupies [i*N +: N]
- out_valid  out  1  outputs hold a valid result
- ba1ba3  out  CH*(M+1)  scaled ba1 + ba3, aligned with ba1ba2ba3
- ba1ba2ba3  out  CH*(M+1)  saturated ba1ba3 + ba2
- Error_out  out  1  Error_previous delayed by one cycle
- sat_count  out  CW  saturating count of lane saturation events
- stall_count  out  CW  saturating count of stall cycles

## Operation
- **Advance condition:** adv = Enable && !Error_previous. When adv is low, every stage register holds its value, including the valid bits.
- **Stage 1 (on adv):**
  - s1_valid <= in_valid.
  - Per lane, s1_sum <= scale(ba1) + ba3, computed at M+1 bits. This sum cannot overflow.
  - Scale modes, each using an arithmetic right shift (floor):
    - Mode 0: ba1 >>> 1
    - Mode 1: (3*ba1) >>> 2
    - Mode 2: ba1
    - Mode 3: (7*ba1) >>> 3, with the intermediate product held at M+3 bits
- **Stage 2 (on adv):**
  - out_valid <= s1_valid.
  - ba1ba3 <= s1_sum.
  - ba1ba2ba3 <= sat(s1_sum + ba2), using an M+2-bit sum clipped to the range [-2^M, 2^M - 1].
  - ba2 is taken from the current input and is not delayed.
- **Counters:**
  - sat_count increases by the number of lanes that clipped, on each stage-2 update where s1_valid = 1.
  - stall_count increases by 1 on every cycle where Error_previous = 1, regardless of Enable.
  - Both counters stick at 2^CW - 1.
- **Error_out:** a register loaded with Error_previous every cycle, independent of Enable.
- **Priority:** Reset > Clear > stall/Enable hold > advance.
- **Flush:** Clear zeroes all data registers, valid bits, Error_out and both counters on the next edge.

## Timing
- **Reset values:** all outputs are 0 (out_valid = 0, Error_out = 0, counters = 0).
- **Latency:** ba1/ba3 reach the outputs 2 advancing edges after they are presented; ba2 reaches the output 1 advancing edge after it is presented.
- **Stall:** an Error_previous pulse of k cycles extends latency by exactly k cycles. No data is lost or duplicated.
- **Error_out timing:** Error_out rises one cycle after Error_previous and falls one cycle after it.
- **Simultaneous Clear and Error_previous:** Clear wins. Error_out is 0 and stall_count is 0 after that edge.
- **Scale_mode change:** affects only data sampled on the same edge; data already in flight is unaffected.
- **Mid-operation Reset:** takes effect immediately and asynchronously. After release, the first valid output appears 2 advancing edges after the first in_valid.

## Test plan
1. **Scaling, modes 1 and 0.** Setup: M=6, N=5; lane0 ba1=20, ba3=10, ba2=15.
   - Mode 1, in_valid for 1 cycle, adv held -> after 2 edges ba1ba3=25, ba1ba2ba3=40, out_valid=1.
   - Mode 0 -> ba1ba3=20, ba1ba2ba3=35.
2. **Negative rounding.** ba1=-1, ba2=ba3=0 in all four modes -> ba1ba3=-1 in modes 0, 1 and 3; -1 in mode 2.
   - ba1=-32 in mode 3 -> scaled value -28.
3. **Saturation.** Setup: M=N=6, mode 2.
   - Lane0: ba1=31, ba3=31, ba2=31 -> ba1ba3=62, ba1ba2ba3=63, sat_count=1.
   - All 4 lanes: ba1=-32, ba3=-32, ba2=-32 -> each lane -64, sat_count increases by 4.
4. **Razor stall.**
   - Stream values 1..6 on consecutive cycles.
   - Assert Error_previous for 3 cycles in the middle of the stream.
   - Required: outputs show 1..6 in order with no gaps or repeats; completion is delayed 3 cycles; Error_out is high for the 3 cycles delayed by one; stall_count=3.
5. **Clear and Reset.**
   - Clear asserted with Error_previous=1 and pipeline full -> next edge: out_valid=0, outputs 0, Error_out=0, counters 0.
   - Reset asserted between edges -> outputs zero immediately.
6. **Counter saturation.** Setup: CW=4; hold Error_previous for 20 cycles -> stall_count stops at 15 and stays there.
